irq_encoder: RTL and testbench
==============================

Name: irq_encoder

Overview:
- 8-to-3 registered priority encoder. It is the encoding counterpart of the team's 3-to-8 decoder.
- It captures rising edges on eight request lines into a pending register, masks them, and presents the highest-index pending request as a 3-bit ID.
- The ID is offered on a valid/ready handshake. A pending bit clears only when its ID is accepted.
- Sits between peripheral event lines and the sequencer or interrupt logic that consumes the decoded ID.

Parameters:
- N_REQ, 8: number of request lines; fixed at 8 for this revision.
- ID_W, 3: ID width, equal to clog2(N_REQ).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_in  in  8  request lines; a 0->1 transition raises a request.
- mask  in  8  1 = line disabled for selection; its pending bit is still recorded.
- id_ready  in  1  consumer accepts id_out this cycle.
- ovf_clr  in  1  clears the overflow flag.
- id_out  out  3  ID of the request being offered.
- id_valid  out  1  id_out is valid.
- onehot_out  out  8  one-hot copy of id_out; all zero when id_valid=0.
- pending  out  8  current pending register.
- overflow  out  1  sticky flag: a request was lost.

Behaviour:
- Reset (rst_n=0, asynchronous) clears: req_q, pending, id_out (3'b000), id_valid, onehot_out, overflow. FSM goes to IDLE.
- Edge detect:
  - req_q <= req_in every cycle; rise = req_in & ~req_q.
  - req_q resets to 0, so a line held high through reset release registers one request.
- Pending update, per bit i, each cycle:
  - pending[i] <= rise[i] | (pending[i] & ~clr[i]).
  - clr[i] = id_valid & id_ready & (id_out==i).
  - Set wins over clear: a rise on a bit being accepted in the same cycle leaves it pending and does not set overflow.
- Overflow:
  - Set when rise[i] & pending[i] & ~clr[i] for any i.
  - Cleared by ovf_clr=1.
  - If set and clear coincide, set wins.
- Selection:
  - cand = pending & ~mask.
  - Winner is the highest set index of cand (bit 7 has highest priority).
- FSM, two states:
  - IDLE: id_valid=0. If cand!=0, register the winner into id_out, set id_valid=1, go to PRESENT. Otherwise stay.
  - PRESENT: id_valid=1. id_out and onehot_out are held stable regardless of later mask/pending changes. On id_ready=1, the handshake completes: clear that pending bit, id_valid<=0, go to IDLE.
  - One bubble cycle always follows each accepted ID.
- Latency:
  - req_in rises before edge k -> pending set after edge k -> id_valid=1 after edge k+1.
  - Total: 2 cycles from sampled rise to valid.
- Masking after presentation does not retract the offered ID; the consumer must still accept it.
- id_ready while id_valid=0 is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package irq_pkg:
  - N_REQ, ID_W;
  - state enum {IDLE, PRESENT};
  - function onehot(id) returning 8 bits.
- Sub-module prio_enc8: purely combinational.
  - Inputs: in[7:0].
  - Outputs: id[2:0] and any.
  - Highest index wins; id=0 when any=0.
- Top level holds edge detect, pending, overflow, FSM and output registers.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while id_valid=1.
  - Required: pending=0, id_valid=0, id_out=0, onehot_out=0, overflow=0 immediately, without waiting for a clock edge.
- Single request:
  - Stimulus: pulse req_in[5] 0->1 with id_ready=1.
  - Required: id_valid=1, id_out=3'b101, onehot_out=8'b00100000 two cycles after the sampled edge; pending=0 after acceptance.
- Priority plus backpressure:
  - Stimulus: rise on bits 2, 6 and 7 in the same cycle; id_ready=0 for 3 cycles, then 1.
  - Required: id_out=7 held stable for 3 cycles. After acceptance, 6 is offered, then 2, each separated by one idle cycle.
- Mask:
  - Stimulus: mask=8'h80; rise on bits 7 and 3.
  - Required: id_out=3 first and pending[7] stays 1. Clear the mask, and 7 is offered next.
- Overflow and set-wins:
  - Stimulus: rise on bit 4 twice before acceptance; then a rise on bit 1 in the same cycle that ID 1 is accepted.
  - Required: overflow=1 after the first case, and stays 1 until ovf_clr. In the second case pending[1] stays 1 and no new overflow is raised.
- Held-high at reset release:
  - Stimulus: req_in[0]=1 through reset deassertion.
  - Required: exactly one ID 0 is offered. No further request is raised while the line stays high.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request priority encoder.
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the highest set index wins.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    // Ascending scan so that the last (highest) set bit overrides lower ones.
    always_comb begin
        id  = '0;
        any = |in;
        for (int i = 0; i < N_REQ; i++) begin
            if (in[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_encoder.sv
// Registered priority encoder: captures request edges into a pending register
// and offers the highest-index unmasked pending request on a valid/ready handshake.
module irq_encoder
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    input  logic             id_ready,
    input  logic             ovf_clr,
    output logic [ID_W-1:0]  id_out,
    output logic             id_valid,
    output logic [N_REQ-1:0] onehot_out,
    output logic [N_REQ-1:0] pending,
    output logic             overflow
);

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] lost;
    logic [N_REQ-1:0] cand;
    logic [ID_W-1:0]  win_id;
    logic             win_any;
    state_t           state;

    // A request arriving on a bit that is being accepted this cycle survives as a new request.
    assign rise = req_in & ~req_q;
    assign clr  = (id_valid && id_ready) ? onehot(id_out) : '0;
    assign lost = rise & pending & ~clr;
    assign cand = pending & ~mask;

    prio_enc8 u_prio (
        .in  (cand),
        .id  (win_id),
        .any (win_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            id_out     <= '0;
            id_valid   <= 1'b0;
            onehot_out <= '0;
            state      <= IDLE;
        end else begin
            req_q   <= req_in;
            pending <= rise | (pending & ~clr);

            if (|lost) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            // The offered ID stays frozen until accepted, even if mask or pending change.
            case (state)
                IDLE: begin
                    if (win_any) begin
                        id_out     <= win_id;
                        onehot_out <= onehot(win_id);
                        id_valid   <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (id_ready) begin
                        onehot_out <= '0;
                        id_valid   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    onehot_out <= '0;
                    id_valid   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_encoder.sv
// Self-checking bench for irq_encoder: directed vector table, corner sequences, random vs. model.
module tb_irq_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       id_ready;
    logic       ovf_clr;
    logic [2:0] id_out;
    logic       id_valid;
    logic [7:0] onehot_out;
    logic [7:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    irq_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .mask       (mask),
        .id_ready   (id_ready),
        .ovf_clr    (ovf_clr),
        .id_out     (id_out),
        .id_valid   (id_valid),
        .onehot_out (onehot_out),
        .pending    (pending),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] msk;
        logic       rdy;
        logic       oclr;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic [7:0] exp_pend;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[28];

    // Reference model state
    logic [7:0] m_reqq;
    logic [7:0] m_pend;
    logic       m_ovf;
    logic       m_valid;
    logic [2:0] m_id;

    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] mk,
                                 input logic rdy, input logic oc);
        req_in   = r;
        mask     = mk;
        id_ready = rdy;
        ovf_clr  = oc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [2:0] eid,
                               input logic [7:0] ep, input logic eo);
        logic [7:0] eoh;
        logic       bad;
        eoh = ev ? (8'd1 << eid) : 8'd0;
        bad = (id_valid !== ev) || (onehot_out !== eoh) || (pending !== ep) ||
              (overflow !== eo) || (ev && (id_out !== eid));
        checks++;
        if (bad) begin
            failures++;
            $display("[TB] FAIL %s: got valid=%0b id=%0d onehot=%02h pend=%02h ovf=%0b, want valid=%0b id=%0d onehot=%02h pend=%02h ovf=%0b",
                     name, id_valid, id_out, onehot_out, pending, overflow, ev, eid, eoh, ep, eo);
        end
    endtask

    task automatic checkValue(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %02h want %02h", name, got, want);
        end
    endtask

    // Behavioural model: one clock edge worth of the encoder's rules.
    task automatic modelStep(input logic [7:0] r, input logic [7:0] mk,
                             input logic rdy, input logic oc);
        logic [7:0] np;
        logic       accept;
        logic       lost;
        logic       found;
        logic       rs;
        logic       cl;
        accept = m_valid && rdy;
        lost   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rs    = r[i] && !m_reqq[i];
            cl    = accept && (int'(m_id) == i);
            np[i] = rs || (m_pend[i] && !cl);
            if (rs && m_pend[i] && !cl) lost = 1'b1;
        end
        if (lost) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        if (!m_valid) begin
            found = 1'b0;
            for (int i = 7; i >= 0; i--) begin
                if (!found && m_pend[i] && !mk[i]) begin
                    found   = 1'b1;
                    m_valid = 1'b1;
                    m_id    = 3'(i);
                end
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        m_pend = np;
        m_reqq = r;
    endtask

    task automatic doReset();
        req_in   = 8'h00;
        mask     = 8'h00;
        id_ready = 1'b0;
        ovf_clr  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reqq  = '0;
        m_pend  = '0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
        m_id    = '0;
    endtask

    initial begin
        int         nvalid;
        logic [2:0] seen_id;
        logic [7:0] r;
        logic [7:0] mk;
        logic       rdy;
        logic       oc;

        // req, mask, rdy, ovf_clr | valid, id, pending, overflow
        vecs[0]  = '{8'h20, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h20, 1'b0};
        vecs[1]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
        vecs[2]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[3]  = '{8'hC4, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'hC4, 1'b0};
        vecs[4]  = '{8'hC4, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'hC4, 1'b0};
        vecs[5]  = '{8'hC4, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'hC4, 1'b0};
        vecs[6]  = '{8'hC4, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'hC4, 1'b0};
        vecs[7]  = '{8'hC4, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h44, 1'b0};
        vecs[8]  = '{8'hC4, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 8'h44, 1'b0};
        vecs[9]  = '{8'hC4, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h04, 1'b0};
        vecs[10] = '{8'hC4, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0};
        vecs[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[12] = '{8'h88, 8'h80, 1'b0, 1'b0, 1'b0, 3'd0, 8'h88, 1'b0};
        vecs[13] = '{8'h88, 8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 8'h88, 1'b0};
        vecs[14] = '{8'h88, 8'h80, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0};
        vecs[15] = '{8'h88, 8'h80, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0};
        vecs[16] = '{8'h88, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0};
        vecs[17] = '{8'h88, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[18] = '{8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 1'b0};
        vecs[19] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0};
        vecs[20] = '{8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b1};
        vecs[21] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b1};
        vecs[22] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
        vecs[23] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h02, 1'b1};
        vecs[24] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0};
        vecs[25] = '{8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h02, 1'b0};
        vecs[26] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0};
        vecs[27] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};

        rst_n = 1'b0;
        doReset();
        #1;
        checkOutput("after_reset", 1'b0, 3'd0, 8'h00, 1'b0);
        checkValue("after_reset_id", {5'd0, id_out}, 8'h00);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].req, vecs[k].msk, vecs[k].rdy, vecs[k].oclr);
            checkOutput($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_id,
                        vecs[k].exp_pend, vecs[k].exp_ovf);
        end

        // Reset asserted mid-cycle while an ID is offered and overflow is set.
        applyStimulus(8'h40, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'h40, 8'h00, 1'b0, 1'b0);
        checkOutput("pre_async_reset", 1'b1, 3'd6, 8'h40, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 3'd0, 8'h00, 1'b0);
        checkValue("async_reset_id", {5'd0, id_out}, 8'h00);

        // Line held high through reset release yields exactly one ID 0.
        req_in   = 8'h01;
        id_ready = 1'b1;
        @(negedge clk);
        rst_n  = 1'b1;
        nvalid = 0;
        seen_id = 3'd7;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (id_valid) begin
                nvalid++;
                seen_id = id_out;
            end
        end
        checkValue("held_high_count", 8'(nvalid), 8'd1);
        checkValue("held_high_id", {5'd0, seen_id}, 8'h00);
        checkOutput("held_high_end", 1'b0, 3'd0, 8'h00, 1'b0);

        // Randomised traffic against the reference model.
        doReset();
        mk = 8'h00;
        r  = 8'h00;
        for (int c = 0; c < 600; c++) begin
            r   = r ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) mk = 8'($urandom) & 8'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            oc  = ($urandom_range(0, 7) == 0);
            modelStep(r, mk, rdy, oc);
            applyStimulus(r, mk, rdy, oc);
            checkOutput($sformatf("rand%0d", c), m_valid, m_id, m_pend, m_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
